// File: rtl/wb_stage.sv
// Write-back stage: retires one instruction per cycle and commits GR/CSR writes,
// exceptions and ertn. Optional trace outputs are enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage #(
    parameter int FLUSH_HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_to_ws_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_final_result,
    input  logic [31:0] ms_vaddr,
    input  logic        ms_gr_we,
    input  logic [4:0]  ms_dest,
    input  logic [6:0]  ms_ex_flags,
    input  logic        ms_ertn,
    input  logic        ms_csr_we,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wdata,
    input  logic [31:0] ms_csr_wmask,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wdata,
    output logic [31:0] csr_wmask,
    output logic        ex_commit,
    output logic [5:0]  ex_ecode,
    output logic [31:0] ex_pc,
    output logic        badv_we,
    output logic [31:0] badv,
    output logic        ertn_commit,
    output logic        ws_block,
    output logic        ws_fwd_we,
    output logic [4:0]  ws_fwd_dest,
    output logic [31:0] ws_fwd_data,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_we,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam logic [3:0] HOLD_INIT  = 4'(FLUSH_HOLD - 1);
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    typedef enum logic {RUN, FLUSH} state_e;

    state_e      state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic        ws_valid_q, ws_valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] result_q, result_d;
    logic [31:0] vaddr_q, vaddr_d;
    logic        gr_we_q, gr_we_d;
    logic [4:0]  dest_q, dest_d;
    logic [6:0]  ex_flags_q, ex_flags_d;
    logic        ertn_q, ertn_d;
    logic        csr_we_q, csr_we_d;
    logic [13:0] csr_num_q, csr_num_d;
    logic [31:0] csr_wdata_q, csr_wdata_d;
    logic [31:0] csr_wmask_q, csr_wmask_d;

    logic        ws_ex;
    logic        commit_flush;
    logic        accept;
    logic [5:0]  ecode_sel;

    // flag order: {has_int, pc_exce, ine, invtlb_op, sys, brk, mem_exce}
    always_comb begin
        ecode_sel = ECODE_INT;
        if (ex_flags_q[6])                       ecode_sel = ECODE_INT;
        else if (ex_flags_q[5])                  ecode_sel = ECODE_ADEF;
        else if (ex_flags_q[4] | ex_flags_q[3])  ecode_sel = ECODE_INE;
        else if (ex_flags_q[2])                  ecode_sel = ECODE_SYS;
        else if (ex_flags_q[1])                  ecode_sel = ECODE_BRK;
        else if (ex_flags_q[0])                  ecode_sel = ECODE_ALE;
    end

    assign ws_ex        = ws_valid_q & (|ex_flags_q);
    assign ertn_commit  = ws_valid_q & ertn_q & ~ws_ex;
    assign commit_flush = ws_ex | ertn_commit;
    // Combinational so the memory stage drops its instruction on the commit edge
    assign ws_block     = commit_flush | (state_q == FLUSH);
    assign ws_allowin   = 1'b1;
    assign accept       = ms_to_ws_valid & ~ws_block;

    assign ex_commit = ws_ex;
    assign ex_ecode  = ws_ex ? ecode_sel : 6'd0;
    assign ex_pc     = pc_q;
    assign badv_we   = ws_ex & ((ecode_sel == ECODE_ADEF) | (ecode_sel == ECODE_ALE));
    assign badv      = !badv_we ? 32'd0 : ((ecode_sel == ECODE_ADEF) ? pc_q : vaddr_q);

    assign rf_we     = ws_valid_q & gr_we_q & ~ws_ex;
    assign rf_waddr  = dest_q;
    assign rf_wdata  = result_q;
    assign csr_we    = ws_valid_q & csr_we_q & ~ws_ex;
    assign csr_num   = csr_num_q;
    assign csr_wdata = csr_wdata_q;
    assign csr_wmask = csr_wmask_q;

    assign ws_fwd_we   = rf_we;
    assign ws_fwd_dest = dest_q;
    assign ws_fwd_data = result_q;

`ifdef WB_DEBUG_TRACE_EN
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest_q;
    assign debug_wb_rf_wdata = result_q;
`else
    assign debug_wb_pc       = 32'd0;
    assign debug_wb_rf_we    = 4'd0;
    assign debug_wb_rf_wnum  = 5'd0;
    assign debug_wb_rf_wdata = 32'd0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            RUN: begin
                if (commit_flush && (HOLD_INIT != 4'd0)) begin
                    state_d    = FLUSH;
                    hold_cnt_d = HOLD_INIT;
                end
            end
            FLUSH: begin
                if (hold_cnt_q <= 4'd1) begin
                    state_d    = RUN;
                    hold_cnt_d = 4'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d    = RUN;
                hold_cnt_d = 4'd0;
            end
        endcase
    end

    always_comb begin
        ws_valid_d  = accept;
        pc_d        = pc_q;
        result_d    = result_q;
        vaddr_d     = vaddr_q;
        gr_we_d     = gr_we_q;
        dest_d      = dest_q;
        ex_flags_d  = ex_flags_q;
        ertn_d      = ertn_q;
        csr_we_d    = csr_we_q;
        csr_num_d   = csr_num_q;
        csr_wdata_d = csr_wdata_q;
        csr_wmask_d = csr_wmask_q;
        if (accept) begin
            pc_d        = ms_pc;
            result_d    = ms_final_result;
            vaddr_d     = ms_vaddr;
            gr_we_d     = ms_gr_we;
            dest_d      = ms_dest;
            ex_flags_d  = ms_ex_flags;
            ertn_d      = ms_ertn;
            csr_we_d    = ms_csr_we;
            csr_num_d   = ms_csr_num;
            csr_wdata_d = ms_csr_wdata;
            csr_wmask_d = ms_csr_wmask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            hold_cnt_q  <= 4'd0;
            ws_valid_q  <= 1'b0;
            pc_q        <= 32'd0;
            result_q    <= 32'd0;
            vaddr_q     <= 32'd0;
            gr_we_q     <= 1'b0;
            dest_q      <= 5'd0;
            ex_flags_q  <= 7'd0;
            ertn_q      <= 1'b0;
            csr_we_q    <= 1'b0;
            csr_num_q   <= 14'd0;
            csr_wdata_q <= 32'd0;
            csr_wmask_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            ws_valid_q  <= ws_valid_d;
            pc_q        <= pc_d;
            result_q    <= result_d;
            vaddr_q     <= vaddr_d;
            gr_we_q     <= gr_we_d;
            dest_q      <= dest_d;
            ex_flags_q  <= ex_flags_d;
            ertn_q      <= ertn_d;
            csr_we_q    <= csr_we_d;
            csr_num_q   <= csr_num_d;
            csr_wdata_q <= csr_wdata_d;
            csr_wmask_q <= csr_wmask_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage built with FLUSH_HOLD=3.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc, ms_final_result, ms_vaddr;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [6:0]  ms_ex_flags;
    logic        ms_ertn, ms_csr_we;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wdata, ms_csr_wmask;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wdata, csr_wmask;
    logic        ex_commit;
    logic [5:0]  ex_ecode;
    logic [31:0] ex_pc;
    logic        badv_we;
    logic [31:0] badv;
    logic        ertn_commit, ws_block;
    logic        ws_fwd_we;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_we;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage #(.FLUSH_HOLD(3)) dut (
        .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_final_result(ms_final_result), .ms_vaddr(ms_vaddr),
        .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_ex_flags(ms_ex_flags), .ms_ertn(ms_ertn),
        .ms_csr_we(ms_csr_we), .ms_csr_num(ms_csr_num), .ms_csr_wdata(ms_csr_wdata),
        .ms_csr_wmask(ms_csr_wmask), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
        .ex_commit(ex_commit), .ex_ecode(ex_ecode), .ex_pc(ex_pc), .badv_we(badv_we),
        .badv(badv), .ertn_commit(ertn_commit), .ws_block(ws_block), .ws_fwd_we(ws_fwd_we),
        .ws_fwd_dest(ws_fwd_dest), .ws_fwd_data(ws_fwd_data), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ms_to_ws_valid  = 1'b0;
        ms_pc           = 32'd0;
        ms_final_result = 32'd0;
        ms_vaddr        = 32'd0;
        ms_gr_we        = 1'b0;
        ms_dest         = 5'd0;
        ms_ex_flags     = 7'd0;
        ms_ertn         = 1'b0;
        ms_csr_we       = 1'b0;
        ms_csr_num      = 14'd0;
        ms_csr_wdata    = 32'd0;
        ms_csr_wmask    = 32'd0;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] res, input logic [31:0] va,
                        input logic gr_we, input logic [4:0] dest, input logic [6:0] flags,
                        input logic ertn, input logic cwe);
        ms_to_ws_valid  = 1'b1;
        ms_pc           = pc;
        ms_final_result = res;
        ms_vaddr        = va;
        ms_gr_we        = gr_we;
        ms_dest         = dest;
        ms_ex_flags     = flags;
        ms_ertn         = ertn;
        ms_csr_we       = cwe;
    endtask

    // After a commit cycle: two FLUSH cycles, then RUN again
    task automatic drain(input string tag);
        set_idle();
        tick();
        tick();
        tick();
        chk(tag, 32'(ws_block), 32'd0);
    endtask

    logic [6:0] tflags [6];
    logic [5:0] tcode  [6];
    logic [3:0] dbg_we_exp;

    initial begin
`ifdef WB_DEBUG_TRACE_EN
        dbg_we_exp = 4'hF;
`else
        dbg_we_exp = 4'h0;
`endif
        tflags = '{7'b0010000, 7'b0001000, 7'b0000100, 7'b0000010, 7'b0000110, 7'b0000011};
        tcode  = '{6'h0D, 6'h0D, 6'h0B, 6'h0C, 6'h0B, 6'h0C};

        set_idle();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_allowin", 32'(ws_allowin), 32'd1);
        chk("rst_block", 32'(ws_block), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_ex", 32'(ex_commit), 32'd0);
        chk("rst_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_dbg_pc", debug_wb_pc, 32'd0);
        reset = 1'b0;

        // normal retire
        send(32'h1c000010, 32'hDEADBEEF, 32'h0, 1'b1, 5'd5, 7'd0, 1'b0, 1'b0);
        tick();
        chk("ret_rf_we", 32'(rf_we), 32'd1);
        chk("ret_waddr", 32'(rf_waddr), 32'd5);
        chk("ret_wdata", rf_wdata, 32'hDEADBEEF);
        chk("ret_fwd_we", 32'(ws_fwd_we), 32'd1);
        chk("ret_fwd_dest", 32'(ws_fwd_dest), 32'd5);
        chk("ret_fwd_data", ws_fwd_data, 32'hDEADBEEF);
        chk("ret_block", 32'(ws_block), 32'd0);
        chk("ret_ex", 32'(ex_commit), 32'd0);
        chk("ret_dbg_we", 32'(debug_wb_rf_we), 32'(dbg_we_exp));
        set_idle();
        tick();
        chk("idle_rf_we", 32'(rf_we), 32'd0);

        // ALE, then flush window with back-to-back instructions
        send(32'h1c000020, 32'h0, 32'h1003, 1'b1, 5'd6, 7'b0000001, 1'b0, 1'b0);
        tick();
        chk("ale_ex", 32'(ex_commit), 32'd1);
        chk("ale_ecode", 32'(ex_ecode), 32'h09);
        chk("ale_badv_we", 32'(badv_we), 32'd1);
        chk("ale_badv", badv, 32'h1003);
        chk("ale_ex_pc", ex_pc, 32'h1c000020);
        chk("ale_rf_we", 32'(rf_we), 32'd0);
        chk("ale_block", 32'(ws_block), 32'd1);
        send(32'h1c000024, 32'h77, 32'h0, 1'b1, 5'd7, 7'd0, 1'b0, 1'b0);
        tick();
        chk("fl1_block", 32'(ws_block), 32'd1);
        chk("fl1_rf_we", 32'(rf_we), 32'd0);
        tick();
        chk("fl2_block", 32'(ws_block), 32'd1);
        chk("fl2_rf_we", 32'(rf_we), 32'd0);
        send(32'h1c000028, 32'h99, 32'h0, 1'b1, 5'd9, 7'd0, 1'b0, 1'b0);
        tick();
        chk("fl3_block", 32'(ws_block), 32'd0);
        chk("fl3_rf_we", 32'(rf_we), 32'd0);
        set_idle();
        send(32'h1c000030, 32'h99, 32'h0, 1'b1, 5'd9, 7'd0, 1'b0, 1'b0);
        tick();
        chk("post_rf_we", 32'(rf_we), 32'd1);
        chk("post_waddr", 32'(rf_waddr), 32'd9);
        chk("post_wdata", rf_wdata, 32'h99);

        // priority: has_int beats pc_exce
        send(32'h1c000034, 32'h0, 32'h44, 1'b0, 5'd0, 7'b1100000, 1'b0, 1'b0);
        tick();
        chk("pri1_ecode", 32'(ex_ecode), 32'h00);
        chk("pri1_ex", 32'(ex_commit), 32'd1);
        chk("pri1_badv_we", 32'(badv_we), 32'd0);
        drain("pri1_drain");

        // priority: pc_exce beats sys
        send(32'h1c000040, 32'h0, 32'h55, 1'b0, 5'd0, 7'b0100100, 1'b0, 1'b0);
        tick();
        chk("pri2_ecode", 32'(ex_ecode), 32'h08);
        chk("pri2_badv_we", 32'(badv_we), 32'd1);
        chk("pri2_badv", badv, 32'h1c000040);
        drain("pri2_drain");

        // ertn carrying a CSR write
        send(32'h1c000050, 32'h0, 32'h0, 1'b0, 5'd0, 7'd0, 1'b1, 1'b1);
        ms_csr_num   = 14'h006;
        ms_csr_wdata = 32'h12;
        ms_csr_wmask = 32'hFFFFFFFF;
        tick();
        chk("ertn_commit", 32'(ertn_commit), 32'd1);
        chk("ertn_csr_we", 32'(csr_we), 32'd1);
        chk("ertn_csr_num", 32'(csr_num), 32'h006);
        chk("ertn_csr_wdata", csr_wdata, 32'h12);
        chk("ertn_ex", 32'(ex_commit), 32'd0);
        chk("ertn_block", 32'(ws_block), 32'd1);
        drain("ertn_drain");

        // ertn with interrupt pending: exception wins, CSR write suppressed
        send(32'h1c000060, 32'h0, 32'h0, 1'b0, 5'd0, 7'b1000000, 1'b1, 1'b1);
        tick();
        chk("ertnint_commit", 32'(ertn_commit), 32'd0);
        chk("ertnint_ex", 32'(ex_commit), 32'd1);
        chk("ertnint_csr_we", 32'(csr_we), 32'd0);
        drain("ertnint_drain");

        for (int i = 0; i < 6; i++) begin
            send(32'h1c000100 + 32'(i * 4), 32'h0, 32'h0, 1'b1, 5'd3, tflags[i], 1'b0, 1'b0);
            tick();
            chk($sformatf("tbl%0d_ecode", i), 32'(ex_ecode), 32'(tcode[i]));
            chk($sformatf("tbl%0d_badv_we", i), 32'(badv_we), 32'd0);
            drain($sformatf("tbl%0d_drain", i));
        end

        // reset in the second FLUSH cycle
        send(32'h1c000200, 32'h0, 32'h0, 1'b0, 5'd0, 7'b0000010, 1'b0, 1'b0);
        tick();
        set_idle();
        tick();
        tick();
        chk("rfl_block_before", 32'(ws_block), 32'd1);
        reset = 1'b1;
        send(32'h1c000204, 32'h5, 32'h0, 1'b1, 5'd3, 7'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        chk("rfl_block", 32'(ws_block), 32'd0);
        chk("rfl_allowin", 32'(ws_allowin), 32'd1);
        chk("rfl_rf_we", 32'(rf_we), 32'd0);
        chk("rfl_ex", 32'(ex_commit), 32'd0);
        send(32'h1c000208, 32'h5A5A, 32'h0, 1'b1, 5'd12, 7'd0, 1'b0, 1'b0);
        tick();
        chk("rfl_after_rf_we", 32'(rf_we), 32'd1);
        chk("rfl_after_waddr", 32'(rf_waddr), 32'd12);
        set_idle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_stage.md
# wb_stage

Final (write-back) pipeline stage of the five-stage LoongArch CPU, directly downstream of the memory stage. It latches one instruction per cycle from the memory stage and commits it: the register-file write, the CSR write, and exception or `ertn` resolution with ecode priority. It drives the pipeline flush (`ws_block`) that cancels all younger stages, provides the forwarding source for decode, and emits the difftest debug trace.

## Interface
Parameters:
- `FLUSH_HOLD`, default 1: number of cycles `ws_block` stays high after an exception or `ertn` commit (range 1–15).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `ms_to_ws_valid` in 1: memory stage offers an instruction.
- `ws_allowin` out 1: write-back stage accepts an instruction this cycle.
- `ms_pc` in 32: instruction PC.
- `ms_final_result` in 32: write-back data.
- `ms_vaddr` in 32: memory address (ALU result).
- `ms_gr_we` in 1: GR write request.
- `ms_dest` in 5: destination GR.
- `ms_ex_flags` in 7: {has_int, pc_exce, ine, invtlb_op, sys, brk, mem_exce}.
- `ms_ertn` in 1: instruction is `ertn`.
- `ms_csr_we` in 1: CSR write request.
- `ms_csr_num` in 14: CSR number.
- `ms_csr_wdata` in 32: CSR write data.
- `ms_csr_wmask` in 32: CSR write mask.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: register-file write port.
- `csr_we` out 1, `csr_num` out 14, `csr_wdata` out 32, `csr_wmask` out 32: CSR write port.
- `ex_commit` out 1: exception taken this cycle.
- `ex_ecode` out 6: exception code.
- `ex_pc` out 32: ERA value.
- `badv_we` out 1, `badv` out 32: BADV update.
- `ertn_commit` out 1: `ertn` retires this cycle.
- `ws_block` out 1: flush of all younger stages.
- `ws_fwd_we` out 1, `ws_fwd_dest` out 5, `ws_fwd_data` out 32: forwarding to decode.
- `debug_wb_pc` out 32, `debug_wb_rf_we` out 4, `debug_wb_rf_wnum` out 5, `debug_wb_rf_wdata` out 32: trace.

## Operation
- Registers: `ws_valid`, a latch of all `ms_*` inputs, state `{RUN, FLUSH}`, and a 4-bit `hold_cnt`.
- Acceptance: in RUN, `ws_allowin`=1. When `ms_to_ws_valid` is high, `ws_valid` is set and the inputs are latched; otherwise `ws_valid` is cleared.
- Exception detect: `ws_ex = ws_valid & |ex_flags`.
- Ecode priority, first match wins:
  - has_int → 0x00
  - pc_exce (ADEF) → 0x08
  - ine or invtlb_op (INE) → 0x0D
  - sys → 0x0B
  - brk → 0x0C
  - mem_exce (ALE) → 0x09
- `badv_we` = `ws_ex` & (ADEF | ALE). `badv` = pc for ADEF, vaddr for ALE.
- `ex_pc` = latched pc.
- `ertn_commit` = `ws_valid & ertn & ~ws_ex`.
- Flush: `ws_block` = `ws_ex | ertn_commit | (state==FLUSH)`. It is combinational in the commit cycle, so the memory stage clears its valid on the same edge.
- On commit, the state goes to FLUSH with `hold_cnt = FLUSH_HOLD-1`. If `FLUSH_HOLD` is 1, the state stays RUN.
- In FLUSH:
  - `ws_allowin`=1, but incoming instructions are discarded and `ws_valid` stays 0.
  - `hold_cnt` decrements each cycle; at 0 the state returns to RUN.
- Commit suppression: `rf_we = ws_valid & gr_we & ~ws_ex`, and `csr_we = ws_valid & csr_we & ~ws_ex`. An excepting instruction writes neither.
- Forwarding: `ws_fwd_we` = `rf_we`, with dest and data taken from the latch.
- Reset: `ws_valid`=0, state RUN, `hold_cnt`=0. All outputs are therefore 0, except `ws_allowin`=1.
- Reset during FLUSH returns the state to RUN immediately.

## Timing
- Latency: 1 cycle. An instruction accepted on edge N commits (rf/csr/ex) during cycle N+1 and writes the register file on edge N+1.
- No back-pressure: one instruction retires per cycle.
- `ws_block` is high for exactly `FLUSH_HOLD` cycles per commit event.
- If `ms_to_ws_valid` is high in an exception cycle, that instruction is dropped: `ws_valid` stays 0 on the next edge.
- Two consecutive excepting instructions cannot both retire; the second is always flushed.
- `debug_wb_rf_we` = `{4{rf_we}}`.

## Configuration
- `WB_DEBUG_TRACE_EN` defined: the `debug_wb_*` outputs are driven from the latched instruction (pc, rf write).
- `WB_DEBUG_TRACE_EN` undefined: all `debug_wb_*` outputs are tied to 0 and their logic is removed; the functional outputs are unchanged.

## Test plan
- Normal retire:
  - Stimulus: valid pc=0x1c000010, gr_we=1, dest=5, result=0xDEADBEEF.
  - Next cycle: rf_we=1, waddr=5, wdata=0xDEADBEEF, fwd matches, ws_block=0.
- ALE:
  - Stimulus: mem_exce=1, vaddr=0x1003, gr_we=1.
  - Required: ex_commit=1, ecode=0x09, badv_we=1, badv=0x1003, rf_we=0, ws_block=1.
- Priority:
  - Stimulus: has_int=1 and pc_exce=1 together.
  - Required: ecode=0x00, badv_we=0.
  - Stimulus: pc_exce plus sys.
  - Required: ecode=0x08, badv=pc.
- ertn with CSR write flag set:
  - Required: ertn_commit=1, csr_we=1 passes through, ws_block=1.
  - With has_int also set: ertn_commit=0, ex_commit=1.
- FLUSH_HOLD=3:
  - Stimulus: exception, then back-to-back valid instructions.
  - Required: ws_block high for 3 cycles; the instructions arriving in the 2 FLUSH cycles produce no rf_we; the next one commits.
- Reset asserted in the second FLUSH cycle:
  - Required: the next cycle has ws_block=0, ws_valid=0, ws_allowin=1.
